mem_access_unit: RTL

//   Owns the MAR and MDR registers of the SLC-3 datapath and sequences SRAM read/write accesses

---
 rtl/mem_access_unit_pkg.sv | 20 ++
 rtl/mem_access_unit_if.sv | 26 ++
 rtl/mem_access_unit_wait.sv | 30 +++
 rtl/mem_access_unit.sv | 103 ++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared types and defaults for the SLC-3 memory access unit.
package mem_pkg;

  // Access sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } mem_state_t;

  // Extra SRAM cycles per access when the instantiator does not override it.
  localparam int WAIT_CYCLES_DEFAULT = 2;

  // Width of the wait counter: enough bits to hold WAIT_CYCLES, never less than one.
  function automatic int cnt_width(input int wait_cycles);
    return (wait_cycles < 1) ? 1 : $clog2(wait_cycles + 1);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Datapath-bus and control-handshake bundle between the control FSM / bus mux
// (master) and the memory access unit (slave).
interface mem_access_unit_if #(
  parameter int N  = 16,
  parameter int AW = 16
);
  logic [N-1:0]  Bus;
  logic          LD_MAR;
  logic          LD_MDR;
  logic          mem_req;
  logic          mem_we;
  logic          mem_busy;
  logic          mem_done;
  logic [AW-1:0] MAR;
  logic [N-1:0]  MDR;

  modport master (
    output Bus, LD_MAR, LD_MDR, mem_req, mem_we,
    input  mem_busy, mem_done, MAR, MDR
  );

  modport slave (
    input  Bus, LD_MAR, LD_MDR, mem_req, mem_we,
    output mem_busy, mem_done, MAR, MDR
  );
endinterface

// File: rtl/mem_access_unit_wait.sv
// Down-counter holding the remaining SRAM wait cycles of the current access.
// Loads at access start, decrements while enabled and parks at zero.
module wait_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  // Load has priority; decrement saturates at zero so the counter never wraps.
  // NOTE: state is updated with non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_access_unit.sv
// SLC-3 memory access unit: owns MAR/MDR and sequences SRAM reads/writes with
// a fixed number of wait cycles behind a req/done handshake.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int N           = 16,
  parameter int AW          = 16,
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
  input  logic          Clk,
  input  logic          Reset_n,
  mem_access_unit_if.slave cpu,
  output logic [AW-1:0] MEM_ADDR,
  output logic          MEM_CE_n,
  output logic          MEM_OE_n,
  output logic          MEM_WE_n,
  output logic [N-1:0]  Data_to_SRAM,
  input  logic [N-1:0]  Data_from_SRAM
);

  localparam int CW = cnt_width(WAIT_CYCLES);

  mem_state_t    state;
  logic [AW-1:0] mar_q;
  logic [N-1:0]  mdr_q;
  logic          busy_q;
  logic          done_q;
  logic          ce_n_q;
  logic          oe_n_q;
  logic          we_n_q;
  logic          accept;
  logic          in_access;
  logic          cnt_zero;

  assign accept    = (state == IDLE) && cpu.mem_req;
  assign in_access = (state == READ) || (state == WRITE);

  wait_counter #(.W(CW)) u_wait (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .load     (accept),
    .load_val (CW'(WAIT_CYCLES)),
    .dec      (in_access),
    .zero     (cnt_zero)
  );

  // Access FSM plus MAR/MDR registers. Strobes, busy and done are registered
  // alongside the state so each always equals the decode of the current state.
  // NOTE: everything here, including the MAR/MDR data registers, has an async reset
  // because reset values are architecturally visible on the bus mux.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state  <= IDLE;
      mar_q  <= '0;
      mdr_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ce_n_q <= 1'b1;
      oe_n_q <= 1'b1;
      we_n_q <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (cpu.LD_MAR) mar_q <= cpu.Bus[AW-1:0];
          if (cpu.LD_MDR) mdr_q <= cpu.Bus;
          if (cpu.mem_req) begin
            state  <= cpu.mem_we ? WRITE : READ;
            busy_q <= 1'b1;
            ce_n_q <= 1'b0;
            oe_n_q <= cpu.mem_we;
            we_n_q <= ~cpu.mem_we;
          end
        end
        READ, WRITE: begin
          if (cnt_zero) begin
            if (state == READ) mdr_q <= Data_from_SRAM;
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            ce_n_q <= 1'b1;
            oe_n_q <= 1'b1;
            we_n_q <= 1'b1;
          end
        end
        default: begin  // DONE: one-cycle pulse, requests ignored
          state  <= IDLE;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign cpu.MAR      = mar_q;
  assign cpu.MDR      = mdr_q;
  assign cpu.mem_busy = busy_q;
  assign cpu.mem_done = done_q;
  assign MEM_ADDR     = mar_q;
  assign Data_to_SRAM = mdr_q;
  assign MEM_CE_n     = ce_n_q;
  assign MEM_OE_n     = oe_n_q;
  assign MEM_WE_n     = we_n_q;

endmodule
